// File: rtl/con_ff_unit.sv
// con_ff_unit: branch-condition evaluator with a valid/ack hold register.
// Evaluates one of eight condition codes on bus, captures the result on a
// con_in strobe and holds it until the control sequencer acknowledges it.
// Optional statistics counters are built only when CON_STATS_EN is defined;
// otherwise eval_cnt/taken_cnt are tied to zero and the ports stay in place.
module con_ff_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus,
  input  logic [2:0]        cond,
  input  logic              con_in,
  input  logic              con_ack,
  output logic              con_out,
  output logic              con_valid,
  output logic              con_ovr,
  output logic [CNT_W-1:0]  eval_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t state_q, state_d;
  logic   out_q, out_d;
  logic   ovr_q, ovr_d;
  logic   flag_z, flag_n, eval;

  // Condition decode: pure function of bus and cond, sampled only on capture.
  always_comb begin
    flag_z = (bus == '0);
    flag_n = bus[DATA_W-1];
    eval   = 1'b0;
    case (cond)
      3'b000:  eval = flag_z;
      3'b001:  eval = !flag_z;
      3'b010:  eval = !flag_n;
      3'b011:  eval = flag_n;
      3'b100:  eval = !flag_n && !flag_z;
      3'b101:  eval = flag_n || flag_z;
      3'b110:  eval = 1'b1;
      default: eval = 1'b0;
    endcase
  end

  // Next state: capture on strobe, release on ack, flag unacknowledged recapture.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (con_in) begin
          state_d = HELD;
          out_d   = eval;
        end
      end
      HELD: begin
        if (con_in) begin
          out_d = eval;
          if (!con_ack) ovr_d = 1'b1;
        end else if (con_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; clr wins over any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  assign con_out   = out_q;
  assign con_valid = (state_q == HELD);
  assign con_ovr   = ovr_q;

`ifdef CON_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // Saturating counters advance on the same edge as the capture.
  always_comb begin
    eval_cnt_d  = eval_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (con_in) begin
      if (eval_cnt_q != '1)          eval_cnt_d  = eval_cnt_q + CNT_ONE;
      if (eval && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  // Counter registers, zeroed by clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      eval_cnt_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      eval_cnt_q  <= eval_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign eval_cnt  = eval_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign eval_cnt  = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_con_ff_unit.sv
// tb_con_ff_unit: directed + random stimulus against a behavioural model.
// A 32-bit instance carries the full check; an 8-bit instance checks the
// sign/zero decode at a narrow width.
module tb_con_ff_unit;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [31:0]   bus = '0;
  logic [7:0]    bus8 = '0;
  logic [2:0]    cond = '0;
  logic          con_in = 1'b0;
  logic          con_ack = 1'b0;
  logic          con_out, con_valid, con_ovr;
  logic [CW-1:0] eval_cnt, taken_cnt;
  logic          con_out8, con_valid8, con_ovr8;
  logic [CW-1:0] eval_cnt8, taken_cnt8;

  con_ff_unit #(.DATA_W(32), .CNT_W(CW)) u_dut (
    .clk(clk), .clr(clr), .bus(bus), .cond(cond), .con_in(con_in),
    .con_ack(con_ack), .con_out(con_out), .con_valid(con_valid),
    .con_ovr(con_ovr), .eval_cnt(eval_cnt), .taken_cnt(taken_cnt)
  );

  con_ff_unit #(.DATA_W(8), .CNT_W(CW)) u_dut8 (
    .clk(clk), .clr(clr), .bus(bus8), .cond(cond), .con_in(con_in),
    .con_ack(con_ack), .con_out(con_out8), .con_valid(con_valid8),
    .con_ovr(con_ovr8), .eval_cnt(eval_cnt8), .taken_cnt(taken_cnt8)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state
  bit m_valid, m_out, m_ovr, m8_out;
  int m_eval, m_taken;

  // Condition table in signed-arithmetic terms.
  function automatic bit ref_eval(input int v, input int c);
    case (c)
      0: return v == 0;
      1: return v != 0;
      2: return v >= 0;
      3: return v < 0;
      4: return v > 0;
      5: return v <= 0;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive on negedge, advance model at posedge, check 1 after.
  task automatic cyc(input bit c_clr, input bit ci, input bit ack,
                     input logic [31:0] b, input int c, input string tag);
    bit r;
    @(negedge clk);
    clr = c_clr; con_in = ci; con_ack = ack; bus = b; cond = c[2:0];
    @(posedge clk);
    if (c_clr) begin
      m_valid = 0; m_out = 0; m_ovr = 0; m_eval = 0; m_taken = 0; m8_out = 0;
    end else if (ci) begin
      r = ref_eval(int'($signed(b)), c);
      if (m_valid && !ack) m_ovr = 1;
      m_out = r; m_valid = 1;
      m8_out = ref_eval(int'($signed(bus8)), c);
`ifdef CON_STATS_EN
      if (m_eval < CMAX) m_eval++;
      if (r && m_taken < CMAX) m_taken++;
`endif
    end else if (ack) begin
      m_valid = 0;
    end
    #1;
    chk({tag, ".out"},   int'(con_out),   int'(m_out));
    chk({tag, ".valid"}, int'(con_valid), int'(m_valid));
    chk({tag, ".ovr"},   int'(con_ovr),   int'(m_ovr));
    chk({tag, ".eval"},  int'(eval_cnt),  m_eval);
    chk({tag, ".taken"}, int'(taken_cnt), m_taken);
    chk({tag, ".out8"},  int'(con_out8),  int'(m8_out));
  endtask

  logic [31:0] sweep [3] = '{32'h0000_0000, 32'h0000_0005, 32'h8000_0000};
  logic [7:0]  w8    [2] = '{8'h80, 8'h7F};
  logic [31:0] rb;

  initial begin
    // 1. reset with strobe held high: outputs stay zero
    cyc(1, 1, 0, 0, 0, "rst0");
    cyc(1, 1, 0, 0, 0, "rst1");
    cyc(0, 1, 0, 0, 0, "rst_cap");
    chk("rst_cap.direct", int'(con_out & con_valid), 1);

    // 2. code sweep, ack with every strobe so no overrun
    cyc(1, 0, 0, 0, 0, "clr");
    foreach (sweep[i])
      for (int c = 0; c < 8; c++) cyc(0, 1, 1, sweep[i], c, "sweep");
    chk("sweep.noovr", int'(con_ovr), 0);

    // 3. handshake
    cyc(1, 0, 0, 0, 0, "clr");
    cyc(0, 1, 0, 7, 1, "hs_cap");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, $urandom, $urandom_range(7), "hs_hold");
    cyc(0, 0, 1, 0, 7, "hs_ack");
    chk("hs_ack.keep", int'(con_out), 1);
    cyc(0, 0, 1, 0, 7, "hs_ack_idle");

    // 4. overrun: sticky until clr; strobe+ack does not set it
    cyc(1, 0, 0, 0, 0, "clr");
    cyc(0, 1, 0, 0, 0, "ov_1");
    cyc(0, 1, 0, 5, 0, "ov_2");
    chk("ov_2.set", int'(con_ovr), 1);
    cyc(0, 0, 1, 0, 0, "ov_ack");
    cyc(0, 0, 0, 0, 0, "ov_idle");
    cyc(1, 0, 0, 0, 0, "ov_clr");
    cyc(0, 1, 0, 0, 6, "ov_h");
    cyc(0, 1, 1, 0, 7, "ov_both");
    chk("ov_both.vld", int'(con_valid), 1);
    // clr mid-HELD discards everything
    cyc(0, 1, 0, 0, 6, "ov_set");
    cyc(1, 1, 0, 0, 6, "clr_mid");

    // 5. statistics saturation and not-taken counting
    cyc(1, 0, 0, 0, 0, "clr");
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, $urandom, 6, "st_sat");
    cyc(1, 0, 0, 0, 0, "clr");
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, $urandom, 7, "st_nt");

    // 6. narrow width decode
    foreach (w8[i]) begin
      bus8 = w8[i];
      for (int c = 0; c < 8; c++) cyc(0, 1, 1, {24'h0, w8[i]}, c, "w8");
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: rb = 32'h0;
        1: rb = 32'h8000_0000;
        2: rb = $urandom_range(3);
        default: rb = $urandom;
      endcase
      bus8 = 8'($urandom);
      cyc($urandom_range(31) == 0, $urandom_range(1), $urandom_range(1),
          rb, $urandom_range(7), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/con_ff_unit.md
# con_ff_unit

- Parametrised branch-condition unit for the datapath.
- Evaluates one of eight condition codes against the bus value on a `con_in` strobe and registers the result as `con_out`.
- Holds the result with a valid/acknowledge handshake so the control sequencer can consume it on a later step, and flags overruns.
- Sits between the bus, the IR condition field and the control unit's branch step.

## Interface
Parameters:
- `DATA_W`, 32: bus width; sign bit is `bus[DATA_W-1]`.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`: in, 1. Rising-edge clock.
- `clr`: in, 1. Reset, synchronous and active-high.
- `bus`: in, `DATA_W`. Operand, two's complement.
- `cond`: in, 3. Condition code, from IR bits.
- `con_in`: in, 1. Evaluate-and-capture strobe.
- `con_ack`: in, 1. Consumer has taken `con_out`.
- `con_out`: out, 1. Registered branch decision.
- `con_valid`: out, 1. `con_out` is fresh and not yet acknowledged.
- `con_ovr`: out, 1. Sticky overrun flag.
- `eval_cnt`: out, `CNT_W`. Number of evaluations.
- `taken_cnt`: out, `CNT_W`. Number of evaluations that captured a 1.

## Operation
Condition codes (Z = bus all-zero, N = sign bit):
- 000: Z (zero).
- 001: !Z (non-zero).
- 010: !N (≥ 0).
- 011: N (< 0).
- 100: !N & !Z (> 0).
- 101: N | Z (≤ 0).
- 110: always 1.
- 111: always 0.

Evaluation:
- Combinational from `bus`/`cond`.
- Captured only on a `clk` edge with `con_in`=1.
- No latch; `con_in` is a clock enable, never a clock.

State machine, two states:
- IDLE (`con_valid`=0):
  - `con_in` → capture, go to HELD.
  - `con_ack` alone is ignored.
- HELD (`con_valid`=1):
  - `con_ack` & !`con_in` → go to IDLE; `con_out` keeps its last value.
  - `con_in` & !`con_ack` → recapture, stay HELD, set `con_ovr`.
  - `con_in` & `con_ack` → recapture, stay HELD, no overrun (old result consumed, new one fresh).
  - Neither → hold.

Other rules:
- `con_out` changes only on capture or `clr`.
- `con_ovr` is set as above and cleared only by `clr`.
- `clr` has priority over everything in the same cycle. Asserting it mid-HELD discards the result, clears `con_ovr`, and zeroes the counters.

Reset values:
- `con_out`=0, `con_valid`=0, `con_ovr`=0, `eval_cnt`=0, `taken_cnt`=0.

## Timing
- Capture latency 1 cycle: strobe sampled at edge k, and `con_out`/`con_valid` update after edge k.
- `bus` and `cond` must be stable at the sampling edge only.
- Back-to-back `con_in` every cycle is legal. Each cycle recaptures, and `con_ovr` sets unless `con_ack` accompanies it.
- `con_ack` takes effect at the edge where it is sampled; `con_valid` falls after that edge.
- Counters update at the same edge as the capture.

## Configuration
Macro `CON_STATS_EN`:
- Defined:
  - `eval_cnt` increments on every capture.
  - `taken_cnt` increments on every capture where the evaluated result is 1.
  - Both saturate at all-ones and do not wrap.
- Not defined:
  - No counter registers are built.
  - `eval_cnt` and `taken_cnt` are tied to 0.
  - Ports remain, so the interface is identical.

## Test plan
1. Reset: `clr`=1 for 2 cycles with `con_in`=1, `bus`=0, `cond`=000 → all outputs 0 throughout; first capture after release gives `con_out`=1, `con_valid`=1.
2. Code sweep with `DATA_W`=32, `bus` ∈ {0x00000000, 0x00000005, 0x80000000}, all eight `cond` → `con_out` matches the table, e.g.:
   - 100 → 0, 1, 0.
   - 101 → 1, 0, 1.
   - 110 → always 1.
   - 111 → always 0.
3. Handshake:
   - Capture (`cond`=001, `bus`=7) → `con_out`=1, `con_valid`=1.
   - Hold 3 cycles → unchanged.
   - `con_ack` → `con_valid`=0 next cycle, `con_out` stays 1.
   - `con_ack` again in IDLE → no change.
4. Overrun:
   - Two `con_in` strobes without `con_ack` → `con_ovr`=1 after the second; it stays set through a later `con_ack`, until `clr`.
   - `con_in`+`con_ack` in the same cycle while HELD → `con_ovr` stays 0, `con_valid` stays 1.
5. Stats with `CON_STATS_EN`, `CNT_W`=4:
   - 20 captures with `cond`=110 → both counters saturate at 15.
   - 3 captures with `cond`=111 → `eval_cnt`=3, `taken_cnt`=0.
   - Without the macro → both counters read 0 always.
6. Width: `DATA_W`=8, `bus`=0x80 → codes 011 and 101 give 1; `bus`=0x7F → codes 010 and 100 give 1.
